// File: rtl/drp_rmw_master_if.sv
// Bundle of command/response and DRP signals shared by the reconfiguration master and its peers.
interface drp_rmw_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_mask;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        pll_rst;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_mask, cmd_data, drp_do, drdy,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, pll_rst, daddr, den, dwe, di
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_mask, cmd_data, drp_do, drdy,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, pll_rst, daddr, den, dwe, di
  );
endinterface

// File: rtl/drp_rmw_master.sv
// DRP initiator: one read or masked read-modify-write per command, with a per-wait timeout
// and an optional PLL reset held across write sequences.
module drp_rmw_master #(
  parameter int TIMEOUT  = 64,
  parameter bit HOLD_RST = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  drp_rmw_master_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic          r_write;
  logic [6:0]    r_addr;
  logic [15:0]   r_mask;
  logic [15:0]   r_data;
  logic [15:0]   r_rdata;
  logic [15:0]   r_di;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_rsp_data;
  logic          r_rsp_err;

  logic          w_drdy;
  logic          w_expired;
  logic [15:0]   w_merged;

  // X/Z on DRDY compares as not-equal, so it never completes an access
  assign w_drdy    = (bus.drdy == 1'b1);
  assign w_expired = (r_cnt == LAST);
  assign w_merged  = (bus.drp_do & r_mask) | (r_data & ~r_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_rdata    <= '0;
      r_di       <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_write <= bus.cmd_write;
            r_addr  <= bus.cmd_addr;
            r_mask  <= bus.cmd_mask;
            r_data  <= bus.cmd_data;
            r_state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          r_cnt   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (w_drdy) begin
            r_rdata <= bus.drp_do;
            r_di    <= w_merged;
            if (r_write) begin
              r_state <= S_WR_REQ;
            end else begin
              r_rsp_data <= bus.drp_do;
              r_rsp_err  <= 1'b0;
              r_state    <= S_RSP;
            end
          end else if (w_expired) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WR_REQ: begin
          r_cnt   <= '0;
          r_state <= S_WR_WAIT;
        end
        // A write timeout still reports the value read before modification
        S_WR_WAIT: begin
          if (w_drdy || w_expired) begin
            r_rsp_data <= r_rdata;
            r_rsp_err  <= !w_drdy;
            r_state    <= S_RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RSP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately
  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.den       = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign bus.dwe       = (r_state == S_WR_REQ);
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.pll_rst   = HOLD_RST && r_write && (r_state != S_IDLE);
  assign bus.daddr     = r_addr;
  assign bus.di        = r_di;

endmodule

// File: tb/tb_drp_rmw_master.sv
// Randomised and directed checks of drp_rmw_master against a transaction-level model
// and a behavioural DRP responder with configurable DRDY latency.
module tb_drp_rmw_master;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drp_rmw_master_if bus();

  drp_rmw_master #(.TIMEOUT(TIMEOUT), .HOLD_RST(1'b1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lastRspCyc = -10;

  logic [15:0] regFile [128];
  logic [15:0] refRegs [128];

  int          rdDelay = 0;
  int          wrDelay = 0;
  int          mode = 0;
  logic [15:0] lastDi = '0;

  int   denCount = 0;
  int   pllCount = 0;
  int   protoErr = 0;
  logic prevDen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Mode 0: DRDY pulses after a delay (-1 = never); 1: DRDY held high except in DEN cycle; 2: DRDY is X
  initial begin
    int          pend;
    logic [6:0]  pendAddr;
    int          d;
    pend = -1;
    pendAddr = '0;
    bus.drdy = 1'b0;
    bus.drp_do = '0;
    forever begin
      @(negedge clk);
      if (mode == 1) bus.drdy = 1'b1;
      else if (mode == 2) bus.drdy = 1'bx;
      else bus.drdy = 1'b0;
      if (!rst_n) begin
        pend = -1;
      end else begin
        if (pend == 0) begin
          bus.drp_do = regFile[pendAddr];
          bus.drdy = 1'b1;
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        if (bus.den === 1'b1) begin
          pendAddr = bus.daddr;
          d = bus.dwe ? wrDelay : rdDelay;
          if (bus.dwe === 1'b1) begin
            lastDi = bus.di;
            regFile[bus.daddr] = bus.di;
          end
          if (mode == 1) begin
            bus.drdy = 1'b0;
            pend = 0;
          end else if (mode == 0 && d >= 0) begin
            pend = d;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.den === 1'b1 && prevDen) protoErr++;
    if (bus.dwe === 1'b1 && bus.den !== 1'b1) protoErr++;
    if (bus.den === 1'b1) denCount++;
    if (bus.pll_rst === 1'b1) pllCount++;
    prevDen = (bus.den === 1'b1);
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Transaction-level expectation: latency, response, DEN count and register effect
  task automatic predict(input bit write, input logic [6:0] addr, input logic [15:0] mask,
                         input logic [15:0] data, input int rd, input int wr,
                         output int lat, output logic [15:0] rdata, output bit err,
                         output int dens, output logic [15:0] expDi);
    bit rdOk, wrOk;
    logic [15:0] old;
    rdOk = (rd >= 0) && (rd < TIMEOUT);
    wrOk = (wr >= 0) && (wr < TIMEOUT);
    old = refRegs[addr];
    expDi = (old & mask) | (data & ~mask);
    lat = 1;
    dens = 1;
    if (!rdOk) begin
      lat += TIMEOUT;
      rdata = 16'h0000;
      err = 1'b1;
    end else begin
      lat += rd + 1;
      rdata = old;
      err = 1'b0;
      if (write) begin
        dens = 2;
        lat += 1 + (wrOk ? wr + 1 : TIMEOUT);
        err = !wrOk;
        refRegs[addr] = expDi;
      end
    end
    lat += 1;
  endtask

  task automatic applyStimulus(input bit write, input logic [6:0] addr, input logic [15:0] mask,
                               input logic [15:0] data, input int rd, input int wr);
    int          expLat, expDens, guard, c0;
    logic [15:0] expData, expDi, heldData;
    bit          expErr, b2b, rdOk;
    predict(write, addr, mask, data, rd, wr, expLat, expData, expErr, expDens, expDi);
    rdOk = (rd >= 0) && (rd < TIMEOUT);
    rdDelay = rd;
    wrDelay = wr;
    denCount = 0;
    pllCount = 0;
    b2b = (cyc == lastRspCyc + 1);
    bus.cmd_write = write;
    bus.cmd_addr = addr;
    bus.cmd_mask = mask;
    bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checkOutput("acceptTimeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    c0 = cyc;
    if (b2b) checkOutput("acceptGap", c0 - lastRspCyc, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr = 7'($urandom);
    bus.cmd_mask = 16'($urandom);
    bus.cmd_data = 16'($urandom);
    guard = 0;
    while (bus.rsp_valid !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checkOutput("rspTimeout", 0, 1);
      return;
    end
    checkOutput("latency", cyc - c0, expLat);
    checkOutput("rspData", int'(bus.rsp_data), int'(expData));
    checkOutput("rspErr", int'(bus.rsp_err), int'(expErr));
    if (write && rdOk) checkOutput("writeDi", int'(lastDi), int'(expDi));
    heldData = bus.rsp_data;
    lastRspCyc = cyc;
    @(negedge clk);
    checkOutput("rspHeld", int'(bus.rsp_data), int'(heldData));
    checkOutput("rspPulse", int'(bus.rsp_valid), 0);
    checkOutput("denCount", denCount, expDens);
    checkOutput("pllCycles", pllCount, write ? expLat : 0);
    checkOutput("readyBack", int'(bus.cmd_ready), 1);
  endtask

  task automatic resetMidWrite(input logic [6:0] addr, input logic [15:0] mask, input logic [15:0] data);
    int guard;
    rdDelay = 0;
    wrDelay = -1;
    refRegs[addr] = (refRegs[addr] & mask) | (data & ~mask);
    bus.cmd_write = 1'b1;
    bus.cmd_addr = addr;
    bus.cmd_mask = mask;
    bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preResetPll", int'(bus.pll_rst), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstDen", int'(bus.den), 0);
    checkOutput("rstDwe", int'(bus.dwe), 0);
    checkOutput("rstPll", int'(bus.pll_rst), 0);
    checkOutput("rstRspValid", int'(bus.rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postResetReady", int'(bus.cmd_ready), 1);
    lastRspCyc = -10;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [15:0] v;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_mask = '0;
    bus.cmd_data = '0;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      regFile[i] = v;
      refRegs[i] = v;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetReady", int'(bus.cmd_ready), 1);
    checkOutput("resetDen", int'(bus.den), 0);
    checkOutput("resetDwe", int'(bus.dwe), 0);
    checkOutput("resetRspValid", int'(bus.rsp_valid), 0);
    checkOutput("resetRspErr", int'(bus.rsp_err), 0);
    checkOutput("resetPll", int'(bus.pll_rst), 0);
    checkOutput("resetDaddr", int'(bus.daddr), 0);
    checkOutput("resetDi", int'(bus.di), 0);
    checkOutput("resetRspData", int'(bus.rsp_data), 0);

    regFile[7'h16] = 16'h1041;
    refRegs[7'h16] = 16'h1041;
    applyStimulus(1'b0, 7'h16, 16'h0000, 16'h0000, 0, 0);
    regFile[7'h08] = 16'hABCD;
    refRegs[7'h08] = 16'hABCD;
    applyStimulus(1'b1, 7'h08, 16'hFF00, 16'h0012, 0, 0);
    checkOutput("rmwDi", int'(lastDi), 16'hAB12);
    applyStimulus(1'b0, 7'h10, 16'h0000, 16'h0000, -1, 0);
    applyStimulus(1'b1, 7'h20, 16'h0F0F, 16'h1234, 0, 10);
    applyStimulus(1'b0, 7'h21, 16'h0000, 16'h0000, TIMEOUT - 1, 0);
    applyStimulus(1'b1, 7'h22, 16'hF0F0, 16'h5A5A, 0, TIMEOUT);

    resetMidWrite(7'h30, 16'h00FF, 16'hBEEF);
    applyStimulus(1'b0, 7'h30, 16'h0000, 16'h0000, 1, 0);

    mode = 1;
    applyStimulus(1'b0, 7'h31, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(1'b1, 7'h31, 16'h3C3C, 16'hC3C3, 0, 0);
    mode = 2;
    applyStimulus(1'b0, 7'h32, 16'h0000, 16'h0000, -1, -1);
    mode = 0;

    for (int n = 0; n < 40; n++) begin
      int rd, wr;
      rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      wr = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      applyStimulus(1'($urandom), 7'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), rd, wr);
    end

    checkOutput("protocol", protoErr, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
